piso_serializer: RTL and testbench
==================================

# piso_serializer

Parallel-in, serial-out transmitter that drives the serial `D` input of the team's SISO shift register chain. It accepts `WIDTH`-bit words over a valid/ready load handshake and buffers one word ahead, so back-to-back words stream with no idle bits. Each word is shifted out one bit per consumer-enabled clock, and a one-cycle `done` pulse marks the end of each word.

## Interface
- `WIDTH`, 8, word length in bits; legal values are ≥ 2.
- `MSB_FIRST`, 1, bit order: 1 sends bit `WIDTH-1` first; 0 sends bit 0 first.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `load_valid`  in  1  `load_data` is offered.
- `load_ready`  out  1  the hold register can accept a word.
- `load_data`  in  WIDTH  parallel word to send.
- `ser_en`  in  1  consumer takes the current bit on this edge.
- `Q`  out  1  serial data bit; feeds SISO `D`.
- `Q_valid`  out  1  `Q` carries a valid bit.
- `done`  out  1  one-cycle pulse: the last bit of a word was consumed.

## Operation
- Storage:
  - Hold register plus `hold_full` flag.
  - Shift register plus a bit counter of width `$clog2(WIDTH)`.
  - State is IDLE or SHIFT.
- Reset (`rst_n`=0, asynchronous, any time including mid-word):
  - `Q`=0, `Q_valid`=0, `done`=0, `load_ready`=1.
  - `hold_full`=0, state=IDLE, counter=0.
  - Any partial or held word is discarded.
- Load handshake:
  - `load_ready` = !`hold_full`, decoded from registered state only.
  - A word is accepted on an edge where `load_valid` && `load_ready`: `load_data` goes to hold and `hold_full` is set.
  - `load_data` is ignored when `load_ready`=0.
- IDLE:
  - `Q_valid`=0, `Q`=0.
  - On an edge with `hold_full`=1: move hold into the shifter, clear `hold_full`, counter=0, go to SHIFT.
  - This transfer does not need `ser_en`.
- SHIFT:
  - `Q_valid`=1.
  - `Q` is the current bit: `MSB_FIRST` ? shifter[`WIDTH-1`] : shifter[0].
  - Edge with `ser_en`=0: nothing changes and `Q` is held stable.
  - Edge with `ser_en`=1 and counter < `WIDTH-1`: shift toward the output end, counter+1.
  - Edge with `ser_en`=1 and counter = `WIDTH-1` (last bit):
    - `done`=1 for the next cycle.
    - If `hold_full`: load the next word, clear `hold_full`, counter=0, stay in SHIFT. `Q_valid` stays 1 with no gap.
    - Otherwise: go to IDLE, `Q_valid`=0, `Q`=0.
- Simultaneous events:
  - Accept and hold-to-shifter transfer cannot fall on the same edge, because `load_ready` is low whenever hold is full.
  - A word accepted on the same edge as the last bit, while hold was empty, goes to hold. Transfer happens on the following edge (IDLE path), which leaves exactly one idle cycle.
- `done` is registered and deasserts after one cycle unless the next word's last bit is consumed on the next edge. With `WIDTH`≥2 that cannot happen.

## Timing
- Load to first bit:
  - Word accepted at edge N (shifter idle).
  - Edge N+1 transfers it to the shifter.
  - `Q`/`Q_valid` show bit 0 of the sequence after edge N+1.
- Bit k is replaced after the k-th `ser_en`=1 edge. A word occupies at least `WIDTH` cycles.
- `done` is high the cycle after the edge that consumed the last bit.
- `load_ready` rises the cycle after hold empties, i.e. after the edge that moved hold into the shifter.
- Sustained throughput is 1 bit/cycle with `ser_en`=1, provided the producer refills hold within `WIDTH-1` cycles of each transfer.
- All outputs are registered or decoded from registers. No combinational path from inputs to outputs.

## Test plan
1. Reset:
   - Drive `rst_n`=0 at start and again mid-word (bit 3 of 8'hC1).
   - Required: `Q`=0, `Q_valid`=0, `done`=0, `load_ready`=1 immediately, with no clock edge needed.
   - After release, the first new word sends cleanly.
2. Single word, `MSB_FIRST`=1, send 8'hC1 with `ser_en`=1:
   - Required `Q`: 1,1,0,0,0,0,0,1 on 8 consecutive cycles with `Q_valid`=1.
   - Required: one `done` pulse, then `Q_valid`=0.
3. Bit order, `MSB_FIRST`=0, send 8'hC1:
   - Required `Q`: 1,0,0,0,0,0,1,1.
   - Required: one `done` pulse.
4. Back-to-back, send 8'hC1 then 8'h3C with `ser_en`=1:
   - Required: 16 contiguous valid bits 11000001 00111100 with no `Q_valid` gap.
   - Required: `done` pulses 8 cycles apart.
   - Required: `load_ready`=0 while hold is full.
5. Stall, send 8'hA5 with `ser_en` pattern 1,0,0,1,1,0,…:
   - Required: `Q` is constant across every `ser_en`=0 cycle.
   - Required: bits 1,0,1,0,0,1,0,1 each appear once; `done` follows the 8th enabled edge only.
6. Backpressure, hold `load_valid`=1 with three words 8'h01, 8'h02, 8'h03:
   - Required: the third word is accepted only after the second moves to the shifter.
   - Required: output bit stream is exactly 01,02,03 in order, no word lost or duplicated.

Source files
------------

// File: rtl/piso_serializer.sv
// piso_serializer
//
// Parallel-in, serial-out transmitter that feeds the serial D input of the
// SISO shift register chain. Words arrive over a valid/ready handshake into a
// one-word hold register, so the next word can be queued while the current
// one is shifting. This lets back-to-back words stream with no idle bits.
//
// Parameters:
//   WIDTH      word length in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous, active-low reset
//   load_valid  producer offers load_data
//   load_ready  hold register is empty and can take a word
//   load_data   parallel word to transmit
//   ser_en      consumer takes the current bit on this edge
//   Q           current serial bit (0 when idle)
//   Q_valid     Q carries a valid bit
//   done        one-cycle pulse after the last bit of a word is consumed

module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_en,
  output logic             Q,
  output logic             Q_valid,
  output logic             done
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] shifted;

  // Bits always leave from the output end; the shifter moves the next bit
  // into that position and back-fills with zeros.
  always_comb begin
    if (MSB_FIRST) begin
      shifted = {shift_q[WIDTH-2:0], 1'b0};
    end else begin
      shifted = {1'b0, shift_q[WIDTH-1:1]};
    end
  end

  // Next-state logic. Accepting a word only happens while hold is empty and
  // moving hold into the shifter only happens while hold is full, so the two
  // updates of hold_full_d below never collide on the same edge.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;

    accept   = load_valid && !hold_full_q;
    last_bit = (cnt_q == LAST_CNT);

    if (accept) begin
      hold_d      = load_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        // Start a word as soon as one is held; the consumer enable is not
        // needed because no bit is consumed by this transfer.
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = '0;
          state_d     = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (ser_en) begin
          if (last_bit) begin
            done_d = 1'b1;
            cnt_d  = '0;
            // Chain straight into the queued word so Q_valid has no gap.
            if (hold_full_q) begin
              shift_d     = hold_q;
              hold_full_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            shift_d = shifted;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset discards any partial or queued word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
    end
  end

  // Outputs decode registered state only, so nothing from the inputs
  // reaches them combinationally. Q is forced low outside SHIFT because the
  // shifter keeps stale contents after a word ends.
  always_comb begin
    Q_valid    = (state_q == ST_SHIFT);
    Q          = Q_valid && (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0]);
    load_ready = !hold_full_q;
    done       = done_q;
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer
//
// Directed bench for piso_serializer. Two instances share all inputs: one
// sends MSB first, the other LSB first, so bit order is checked on the same
// stimulus. Inputs change and outputs are sampled 1 ns after each rising edge.

module tb_piso_serializer;

  logic       clk;
  logic       rst_n;
  logic       load_valid;
  logic [7:0] load_data;
  logic       ser_en;

  logic m_ready, m_q, m_qv, m_done;
  logic l_ready, l_q, l_qv, l_done;

  int checks = 0;
  int fails  = 0;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (m_ready),
    .load_data  (load_data),
    .ser_en     (ser_en),
    .Q          (m_q),
    .Q_valid    (m_qv),
    .done       (m_done)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (l_ready),
    .load_data  (load_data),
    .ser_en     (ser_en),
    .Q          (l_q),
    .Q_valid    (l_qv),
    .done       (l_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runaway guard in case a loop never exits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic lv, input logic [7:0] data, input logic en);
    load_valid = lv;
    load_data  = data;
    ser_en     = en;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one word with ser_en held high and check the 8 bits on the chosen
  // instance against a hand-written bit string (first bit at [7]).
  task automatic sendSingle(input logic [7:0] word, input bit use_lsb,
                            input logic [7:0] exp_bits, input string tag);
    logic q, qv, dn;
    applyStimulus(1'b1, word, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput({tag, "_wait_valid"}, 32'(m_qv), 32'd0);
    tick();
    for (int k = 0; k < 8; k++) begin
      q  = use_lsb ? l_q : m_q;
      qv = use_lsb ? l_qv : m_qv;
      dn = use_lsb ? l_done : m_done;
      checkOutput($sformatf("%s_bit%0d", tag, k), 32'(q), 32'(exp_bits[7-k]));
      checkOutput($sformatf("%s_valid%0d", tag, k), 32'(qv), 32'd1);
      checkOutput($sformatf("%s_done%0d", tag, k), 32'(dn), 32'd0);
      tick();
    end
    dn = use_lsb ? l_done : m_done;
    qv = use_lsb ? l_qv : m_qv;
    checkOutput({tag, "_done_pulse"}, 32'(dn), 32'd1);
    checkOutput({tag, "_end_valid"}, 32'(qv), 32'd0);
    checkOutput({tag, "_end_q"}, 32'(use_lsb ? l_q : m_q), 32'd0);
    tick();
    checkOutput({tag, "_done_clear"}, 32'(use_lsb ? l_done : m_done), 32'd0);
  endtask

  initial begin
    logic [15:0] stream16;
    logic [23:0] stream24;
    logic [7:0]  words [3];
    logic [5:0]  pat;
    logic        en, prev_q, accept_now;
    int          nbits, cyc, widx, gaps;

    // ---------------- Reset at start ----------------
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    #2;
    checkOutput("rst0_q", 32'(m_q), 32'd0);
    checkOutput("rst0_qv", 32'(m_qv), 32'd0);
    checkOutput("rst0_done", 32'(m_done), 32'd0);
    checkOutput("rst0_ready", 32'(m_ready), 32'd1);
    checkOutput("rst0_ready_lsb", 32'(l_ready), 32'd1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // ---------------- Reset mid-word with a word queued ----------------
    applyStimulus(1'b1, 8'hC1, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b1, 8'h3C, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    tick();
    checkOutput("mid_pre_qv", 32'(m_qv), 32'd1);
    checkOutput("mid_pre_ready", 32'(m_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_q", 32'(m_q), 32'd0);
    checkOutput("mid_rst_qv", 32'(m_qv), 32'd0);
    checkOutput("mid_rst_done", 32'(m_done), 32'd0);
    checkOutput("mid_rst_ready", 32'(m_ready), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("post_rst_idle%0d", i), 32'(m_qv), 32'd0);
    end

    // ---------------- Single word, both bit orders ----------------
    sendSingle(8'hC1, 1'b0, 8'b1100_0001, "msb_c1");
    sendSingle(8'hC1, 1'b1, 8'b1000_0011, "lsb_c1");

    // ---------------- Back-to-back C1 then 3C ----------------
    stream16 = 16'b1100_0001_0011_1100;
    applyStimulus(1'b1, 8'hC1, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b1, 8'h3C, 1'b1);
    for (int c = 0; c < 16; c++) begin
      checkOutput($sformatf("b2b_bit%0d", c), 32'(m_q), 32'(stream16[15-c]));
      checkOutput($sformatf("b2b_valid%0d", c), 32'(m_qv), 32'd1);
      if (c >= 1 && c <= 7)
        checkOutput($sformatf("b2b_ready%0d", c), 32'(m_ready), 32'd0);
      tick();
      if (c == 0) applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput($sformatf("b2b_done%0d", c), 32'(m_done),
                  (c == 7 || c == 15) ? 32'd1 : 32'd0);
    end
    checkOutput("b2b_end_valid", 32'(m_qv), 32'd0);
    tick();

    // ---------------- Stall pattern on A5 ----------------
    pat = 6'b100110;
    applyStimulus(1'b1, 8'hA5, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("stall_start_valid", 32'(m_qv), 32'd1);
    nbits = 0;
    cyc   = 0;
    while (nbits < 8 && cyc < 40) begin
      en     = pat[5 - (cyc % 6)];
      ser_en = en;
      prev_q = m_q;
      if (en)
        checkOutput($sformatf("stall_bit%0d", nbits), 32'(m_q), 32'(8'hA5 >> (7 - nbits)) & 32'd1);
      checkOutput($sformatf("stall_valid_c%0d", cyc), 32'(m_qv), 32'd1);
      tick();
      if (en) nbits++;
      checkOutput($sformatf("stall_done_c%0d", cyc), 32'(m_done),
                  (en && nbits == 8) ? 32'd1 : 32'd0);
      if (!en)
        checkOutput($sformatf("stall_hold_c%0d", cyc), 32'(m_q), 32'(prev_q));
      cyc++;
    end
    checkOutput("stall_nbits", 32'(nbits), 32'd8);
    checkOutput("stall_end_valid", 32'(m_qv), 32'd0);
    ser_en = 1'b1;
    tick();

    // ---------------- Backpressure: 01, 02, 03 with load_valid held ----------------
    words[0] = 8'h01;
    words[1] = 8'h02;
    words[2] = 8'h03;
    widx     = 0;
    nbits    = 0;
    gaps     = 0;
    stream24 = '0;
    applyStimulus(1'b1, words[0], 1'b1);
    cyc = 0;
    while (nbits < 24 && cyc < 80) begin
      accept_now = load_valid && m_ready;
      if (accept_now && widx == 2)
        checkOutput("bp_third_after_second", 32'(nbits), 32'd8);
      if (m_qv) begin
        stream24 = {stream24[22:0], m_q};
        nbits++;
      end else if (nbits > 0) begin
        gaps++;
      end
      tick();
      if (accept_now) begin
        widx++;
        if (widx < 3) load_data = words[widx];
        else          load_valid = 1'b0;
      end
      cyc++;
    end
    checkOutput("bp_nbits", 32'(nbits), 32'd24);
    checkOutput("bp_stream", 32'(stream24), 32'h010203);
    checkOutput("bp_gaps", 32'(gaps), 32'd0);
    checkOutput("bp_accepted", 32'(widx), 32'd3);
    checkOutput("bp_end_done", 32'(m_done), 32'd1);
    checkOutput("bp_end_valid", 32'(m_qv), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
